// File: rtl/ram_93422_arbiter.sv
// ram_93422_arbiter
//
// Time-shares a single 256x4 93422-style static RAM between three users:
// the video scanner (read-only), the CPU (read/write, req/ack handshake) and
// a clear engine that fills every location with CLEAR_VALUE.
//
// Clocks alternate between two access slots. Phase 0 always belongs to the
// video scanner; phase 1 is shared, with clear taking priority over the CPU.
// Every RAM pin is registered so it changes only at the edge that starts an
// access cycle. The asynchronous read data is captured at the edge that ends
// that cycle.
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   vid_en, vid_addr       video read request/address for the next video slot
//   vid_data, vid_valid    captured video data and its one-cycle strobe
//   cpu_req, cpu_we,
//   cpu_addr, cpu_wdata    CPU request (level), held stable until cpu_ack
//   cpu_ack, cpu_rdata     one-cycle completion pulse and read data
//   clr_start              starts a full-RAM clear when idle
//   clr_busy, clr_done     clear in progress / one-cycle completion pulse
//   ram_a, ram_i           RAM address and write data
//   ram_cs1_n, ram_w_n     RAM chip select and write enable, active low
//   ram_d                  asynchronous RAM read data
module ram_93422_arbiter #(
    parameter logic [3:0] CLEAR_VALUE = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vid_en,
    input  logic [7:0] vid_addr,
    output logic [3:0] vid_data,
    output logic       vid_valid,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [3:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [3:0] cpu_rdata,
    input  logic       clr_start,
    output logic       clr_busy,
    output logic       clr_done,
    output logic [7:0] ram_a,
    output logic [3:0] ram_i,
    output logic       ram_cs1_n,
    output logic       ram_w_n,
    input  logic [3:0] ram_d
);

    typedef enum logic {
        PH_VIDEO  = 1'b0,
        PH_SHARED = 1'b1
    } phase_t;

    // The access occupying the RAM during the current cycle; it decides what
    // happens at the edge that ends that cycle.
    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_VID  = 2'd1,
        ACC_CPU  = 2'd2,
        ACC_CLR  = 2'd3
    } access_t;

    phase_t     phase, phase_n;
    access_t    access, access_n;
    logic       cpu_read, cpu_read_n;
    logic [7:0] counter, counter_n;

    logic [3:0] vid_data_n;
    logic       vid_valid_n;
    logic       cpu_ack_n;
    logic [3:0] cpu_rdata_n;
    logic       clr_busy_n;
    logic       clr_done_n;
    logic [7:0] ram_a_n;
    logic [3:0] ram_i_n;
    logic       ram_cs1_n_n;
    logic       ram_w_n_n;

    // State register. Phase resets to the shared slot so the first edge after
    // reset is released opens a video slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= PH_SHARED;
            access    <= ACC_NONE;
            cpu_read  <= 1'b0;
            counter   <= 8'h00;
            vid_data  <= 4'h0;
            vid_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= 4'h0;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
            ram_a     <= 8'h00;
            ram_i     <= 4'h0;
            ram_cs1_n <= 1'b1;
            ram_w_n   <= 1'b1;
        end else begin
            phase     <= phase_n;
            access    <= access_n;
            cpu_read  <= cpu_read_n;
            counter   <= counter_n;
            vid_data  <= vid_data_n;
            vid_valid <= vid_valid_n;
            cpu_ack   <= cpu_ack_n;
            cpu_rdata <= cpu_rdata_n;
            clr_busy  <= clr_busy_n;
            clr_done  <= clr_done_n;
            ram_a     <= ram_a_n;
            ram_i     <= ram_i_n;
            ram_cs1_n <= ram_cs1_n_n;
            ram_w_n   <= ram_w_n_n;
        end
    end

    // Next-state logic. First retire the access that ends at this edge
    // (capture read data, pulse strobes, advance the clear counter), then
    // grant the slot that this edge opens.
    always_comb begin
        phase_n     = phase;
        access_n    = ACC_NONE;
        cpu_read_n  = cpu_read;
        counter_n   = counter;
        vid_data_n  = vid_data;
        vid_valid_n = 1'b0;
        cpu_ack_n   = 1'b0;
        cpu_rdata_n = cpu_rdata;
        clr_busy_n  = clr_busy;
        clr_done_n  = 1'b0;
        ram_a_n     = ram_a;
        ram_i_n     = ram_i;
        ram_cs1_n_n = 1'b1;
        ram_w_n_n   = 1'b1;

        case (access)
            ACC_VID: begin
                vid_data_n  = ram_d;
                vid_valid_n = 1'b1;
            end
            ACC_CPU: begin
                cpu_ack_n = 1'b1;
                if (cpu_read) begin
                    cpu_rdata_n = ram_d;
                end
            end
            ACC_CLR: begin
                // The counter wraps to zero after address 255, leaving it
                // ready for the next clear.
                counter_n = counter + 8'd1;
                if (counter == 8'hFF) begin
                    clr_busy_n = 1'b0;
                    clr_done_n = 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (phase == PH_SHARED) begin
            // Opening a video slot. A clear may also be requested here; its
            // first write then happens in the following shared slot.
            phase_n = PH_VIDEO;
            if (clr_start && !clr_busy) begin
                clr_busy_n = 1'b1;
                counter_n  = 8'h00;
            end
            if (vid_en) begin
                ram_a_n     = vid_addr;
                ram_cs1_n_n = 1'b0;
                access_n    = ACC_VID;
            end
        end else begin
            // Opening a shared slot: clear beats the CPU, including a clear
            // requested at this very edge (the counter is zero when idle).
            phase_n = PH_SHARED;
            if (clr_busy || clr_start) begin
                clr_busy_n  = 1'b1;
                ram_a_n     = counter;
                ram_i_n     = CLEAR_VALUE;
                ram_cs1_n_n = 1'b0;
                ram_w_n_n   = 1'b0;
                access_n    = ACC_CLR;
            end else if (cpu_req) begin
                ram_a_n     = cpu_addr;
                ram_i_n     = cpu_wdata;
                ram_cs1_n_n = 1'b0;
                ram_w_n_n   = ~cpu_we;
                cpu_read_n  = ~cpu_we;
                access_n    = ACC_CPU;
            end
        end
    end

endmodule

// File: tb/tb_ram_93422_arbiter.sv
// Self-checking bench for ram_93422_arbiter with a behavioural RAM and a
// transaction-level model that predicts every DUT output on every cycle.
module tb_ram_93422_arbiter;

    localparam logic [3:0] CLR_VAL = 4'h9;

    localparam int K_NONE = 0;
    localparam int K_VID  = 1;
    localparam int K_CPUR = 2;
    localparam int K_CPUW = 3;
    localparam int K_CLR  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       vid_en;
    logic [7:0] vid_addr;
    logic [3:0] vid_data;
    logic       vid_valid;
    logic       cpu_req;
    logic       cpu_we;
    logic [7:0] cpu_addr;
    logic [3:0] cpu_wdata;
    logic       cpu_ack;
    logic [3:0] cpu_rdata;
    logic       clr_start;
    logic       clr_busy;
    logic       clr_done;
    logic [7:0] ram_a;
    logic [3:0] ram_i;
    logic       ram_cs1_n;
    logic       ram_w_n;
    logic [3:0] ram_d;

    int checks = 0;
    int errors = 0;

    ram_93422_arbiter #(.CLEAR_VALUE(CLR_VAL)) dut (
        .clk(clk), .reset(reset),
        .vid_en(vid_en), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_a(ram_a), .ram_i(ram_i), .ram_cs1_n(ram_cs1_n), .ram_w_n(ram_w_n),
        .ram_d(ram_d)
    );

    always #5 clk = ~clk;

    // Behavioural 93422: asynchronous read, write committed at the end of a
    // selected write cycle. A bulk image load stands in for prior contents.
    logic [3:0] mem [256];
    logic [3:0] load_img [256];
    logic       load_req = 1'b0;

    assign ram_d = ram_cs1_n ? 4'h0 : mem[ram_a];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] = load_img[i];
        end else if (!ram_cs1_n && !ram_w_n) begin
            mem[ram_a] = ram_i;
        end
    end

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the slot parity, the access in flight and a
    // shadow of RAM contents, and from those derives every output.
    bit         m_valid = 1'b0;
    int         m_phase;
    int         p_kind;
    logic [7:0] p_addr;
    logic [3:0] p_data;
    logic [3:0] shadow [256];
    bit         m_busy;
    int         m_clr_count;
    logic [7:0] e_ram_a;
    logic [3:0] e_ram_i, e_vdata, e_rdata;
    logic       e_cs, e_w, e_vvalid, e_ack, e_busy, e_done;

    task automatic model_step();
        bit busy_pre;
        busy_pre = m_busy;
        if (p_kind == K_CPUW) shadow[p_addr] = p_data;
        if (p_kind == K_CLR)  shadow[p_addr] = CLR_VAL;
        if (reset) begin
            m_valid = 1'b1; m_phase = 1; p_kind = K_NONE; m_busy = 1'b0; m_clr_count = 0;
            e_ram_a = 8'h00; e_ram_i = 4'h0; e_cs = 1'b1; e_w = 1'b1;
            e_vdata = 4'h0; e_vvalid = 1'b0; e_ack = 1'b0; e_rdata = 4'h0;
            e_busy = 1'b0; e_done = 1'b0;
        end else if (m_valid) begin
            e_vvalid = 1'b0; e_ack = 1'b0; e_done = 1'b0;
            case (p_kind)
                K_VID:  begin e_vvalid = 1'b1; e_vdata = shadow[p_addr]; end
                K_CPUR: begin e_ack = 1'b1; e_rdata = shadow[p_addr]; end
                K_CPUW: e_ack = 1'b1;
                K_CLR: begin
                    m_clr_count++;
                    if (m_clr_count == 256) begin
                        m_busy = 1'b0; e_done = 1'b1; m_clr_count = 0;
                    end
                end
                default: ;
            endcase
            p_kind = K_NONE;
            e_cs = 1'b1; e_w = 1'b1;
            if (m_phase == 1) begin
                if (clr_start && !busy_pre) m_busy = 1'b1;
                if (vid_en) begin
                    p_kind = K_VID; p_addr = vid_addr; e_ram_a = vid_addr; e_cs = 1'b0;
                end
                m_phase = 0;
            end else begin
                if (busy_pre || clr_start) begin
                    m_busy = 1'b1; p_kind = K_CLR; p_addr = m_clr_count[7:0];
                    e_ram_a = p_addr; e_ram_i = CLR_VAL; e_cs = 1'b0; e_w = 1'b0;
                end else if (cpu_req) begin
                    p_kind = cpu_we ? K_CPUW : K_CPUR; p_addr = cpu_addr; p_data = cpu_wdata;
                    e_ram_a = cpu_addr; e_ram_i = cpu_wdata; e_cs = 1'b0; e_w = ~cpu_we;
                end
                m_phase = 1;
            end
            e_busy = m_busy;
        end
        if (load_req) begin
            for (int i = 0; i < 256; i++) shadow[i] = load_img[i];
        end
    endtask

    // Single compare process: advance the model on each edge, then check all
    // outputs shortly after the edge once the model has seen a reset.
    always @(posedge clk) begin
        model_step();
        #1;
        if (m_valid) begin
            check_output("ram_a", ram_a, e_ram_a);
            check_output("ram_i", ram_i, e_ram_i);
            check_output("ram_cs1_n", ram_cs1_n, e_cs);
            check_output("ram_w_n", ram_w_n, e_w);
            check_output("vid_valid", vid_valid, e_vvalid);
            check_output("vid_data", vid_data, e_vdata);
            check_output("cpu_ack", cpu_ack, e_ack);
            check_output("cpu_rdata", cpu_rdata, e_rdata);
            check_output("clr_busy", clr_busy, e_busy);
            check_output("clr_done", clr_done, e_done);
        end
    end

    // Event counters sampled mid-cycle for the directed checks.
    int cyc = 0, busy_cyc = 0, done_cnt = 0, wr_cyc = 0, vstrobe = 0, ack_cnt = 0;
    int last_ack_cyc = 0, busy_fall_cyc = 0;
    bit prev_busy = 1'b0;
    always @(posedge clk) begin
        cyc++;
        #2;
        if (clr_busy) busy_cyc++;
        if (clr_done) done_cnt++;
        if (!ram_cs1_n && !ram_w_n) wr_cyc++;
        if (vid_valid) vstrobe++;
        if (cpu_ack) begin ack_cnt++; last_ack_cyc = cyc; end
        if (prev_busy && !clr_busy) busy_fall_cyc = cyc;
        prev_busy = clr_busy;
    end

    // Video driver: 0 idle, 1 random, 2 incrementing, 3 directed.
    int         vid_mode = 0;
    logic       dir_en = 1'b0;
    logic [7:0] dir_addr = 8'h00;
    always @(negedge clk) begin
        case (vid_mode)
            1: begin vid_en = 1'($urandom); vid_addr = 8'($urandom); end
            2: begin vid_en = 1'b1; vid_addr = vid_addr + 8'd1; end
            3: begin vid_en = dir_en; vid_addr = dir_addr; end
            default: vid_en = 1'b0;
        endcase
    end

    // Waits to a falling edge inside a cycle of the given phase.
    task automatic align_to(input int p);
        @(negedge clk);
        while (m_phase != p) @(negedge clk);
    endtask

    task automatic cpu_xfer(input logic we, input logic [7:0] addr, input logic [3:0] wd,
                            output logic [3:0] rd);
        bit got;
        got = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (cpu_ack) begin got = 1'b1; break; end
        end
        rd = cpu_rdata;
        cpu_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL cpu_timeout: no ack for addr 0x%0h, expected ack within 1500 cycles", addr);
        end
    endtask

    task automatic load_image(input int salt);
        for (int i = 0; i < 256; i++) load_img[i] = 4'((i * 5 + salt) & 7);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic pulse_clr_start();
        @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
    endtask

    task automatic apply_stimulus();
        logic [3:0] rd;
        int         n0, n1, t0, bad;

        // Reset and initial RAM contents.
        for (int i = 0; i < 256; i++) load_img[i] = 4'($urandom);
        load_img[8'h5A] = 4'hC;
        load_req = 1'b1;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 4'h0;
        clr_start = 1'b0; vid_addr = 8'h00;
        @(negedge clk);
        load_req = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_cs1_n", ram_cs1_n, 1'b1);
        check_output("rst_w_n", ram_w_n, 1'b1);
        check_output("rst_busy", clr_busy, 1'b0);
        reset = 1'b0;

        // Directed video read of 0x5A.
        vid_mode = 3;
        align_to(0);
        #1 dir_en = 1'b1; dir_addr = 8'h5A;
        @(negedge clk);
        @(negedge clk);
        check_output("vid_ram_a", ram_a, 8'h5A);
        check_output("vid_cs1_n", ram_cs1_n, 1'b0);
        #1 dir_en = 1'b0;
        @(negedge clk);
        check_output("vid_valid_hi", vid_valid, 1'b1);
        check_output("vid_data_5a", vid_data, 4'hC);
        @(negedge clk);
        check_output("vid_valid_lo", vid_valid, 1'b0);

        // CPU write then read of 0x33 while video runs randomly.
        vid_mode = 1;
        n0 = wr_cyc;
        cpu_xfer(1'b1, 8'h33, 4'h7, rd);
        check_output("cpu_wr_cycles", 8'(wr_cyc - n0), 8'd1);
        cpu_xfer(1'b0, 8'h33, 4'h0, rd);
        check_output("cpu_rd_33", rd, 4'h7);

        // Random CPU traffic against random video traffic.
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            cpu_xfer(1'($urandom), 8'($urandom), 4'($urandom), rd);
        end

        // Back-to-back reads with incrementing video addresses.
        vid_mode = 2;
        repeat (2) @(negedge clk);
        n0 = vstrobe;
        cpu_xfer(1'b0, 8'h10, 4'h0, rd);
        t0 = last_ack_cyc;
        for (int k = 0; k < 9; k++) cpu_xfer(1'b0, 8'(8'h11 + k), 4'h0, rd);
        check_output("ack_period", 8'(last_ack_cyc - t0), 8'd36);
        n1 = vstrobe - n0;
        check_output("vid_strobes", 8'((n1 >= 19 && n1 <= 21) ? 1 : 0), 8'd1);

        // Full clear with a late CPU read and an ignored second start.
        vid_mode = 1;
        align_to(1);
        n0 = busy_cyc; n1 = done_cnt;
        #1 clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        fork
            begin
                repeat (9) @(negedge clk);
                cpu_xfer(1'b0, 8'h33, 4'h0, rd);
            end
            begin
                repeat (200) @(negedge clk);
                pulse_clr_start();
            end
        join
        repeat (4) @(negedge clk);
        check_output("clr_busy_len", 8'((busy_cyc - n0) == 512 ? 1 : 0), 8'd1);
        check_output("clr_done_cnt", 8'(done_cnt - n1), 8'd1);
        check_output("clr_cpu_ack_time", 8'(last_ack_cyc - busy_fall_cyc), 8'd2);
        check_output("clr_cpu_rd", rd, CLR_VAL);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== CLR_VAL) bad++;
        check_output("clr_all_9", 8'(bad), 8'd0);

        // Collision: clear and CPU read requested at the same shared edge.
        vid_mode = 0;
        repeat (3) @(negedge clk);
        load_image(1);
        vid_mode = 1;
        align_to(0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h44; cpu_wdata = 4'h0;
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        check_output("col_ram_a", ram_a, 8'h00);
        check_output("col_ram_i", ram_i, CLR_VAL);
        check_output("col_w_n", ram_w_n, 1'b0);
        check_output("col_ack", cpu_ack, 1'b0);
        t0 = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (cpu_ack) begin t0 = 1; break; end
        end
        rd = cpu_rdata;
        cpu_req = 1'b0;
        check_output("col_acked", 8'(t0), 8'd1);
        check_output("col_ack_time", 8'(last_ack_cyc - busy_fall_cyc), 8'd2);
        check_output("col_rd", rd, CLR_VAL);

        // Reset in the middle of a clear, just before address 0x80 is granted.
        vid_mode = 0;
        repeat (3) @(negedge clk);
        load_image(2);
        vid_mode = 1;
        align_to(1);
        #1 clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        t0 = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (m_clr_count == 128 && m_phase == 0) begin t0 = 1; break; end
        end
        check_output("mid_reached", 8'(t0), 8'd1);
        n1 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("mid_busy", clr_busy, 1'b0);
        check_output("mid_cs1_n", ram_cs1_n, 1'b1);
        check_output("mid_ram_a", ram_a, 8'h00);
        check_output("mid_vvalid", vid_valid, 1'b0);
        repeat (600) @(negedge clk);
        check_output("mid_no_done", 8'(done_cnt - n1), 8'd0);
        bad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== CLR_VAL) bad++;
        check_output("mid_low_clr", 8'(bad), 8'd0);
        bad = 0;
        for (int i = 128; i < 256; i++) if (mem[i] !== 4'((i * 5 + 2) & 7)) bad++;
        check_output("mid_high_kept", 8'(bad), 8'd0);
        vid_mode = 0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        apply_stimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, expected finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/ram_93422_arbiter.md
Name: ram_93422_arbiter

Overview:
- Time-shares one 256x4 93422-style static RAM between three requesters: the video scanner (read-only), the CPU (read/write, req/ack handshake) and a built-in clear engine that fills the whole RAM.
- Sits between the RAM instance and the video/CPU logic.
- The block owns every RAM control pin.
- The RAM read path is asynchronous; this block registers all RAM inputs and captures read data.

Parameters:
- CLEAR_VALUE, 4'h0, nibble written to every location by the clear engine.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vid_en  in  1  video read request for the next video slot
- vid_addr  in  8  video read address
- vid_data  out  4  registered video read data
- vid_valid  out  1  one-cycle strobe qualifying vid_data
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  8  CPU address; stable while cpu_req is high
- cpu_wdata  in  4  CPU write data; stable while cpu_req is high
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  4  read data; valid while cpu_ack is high
- clr_start  in  1  start a full-RAM clear
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after the final clear write
- ram_a  out  8  RAM address
- ram_i  out  4  RAM write data
- ram_cs1_n  out  1  RAM chip select, active low
- ram_w_n  out  1  RAM write enable, active low
- ram_d  in  4  RAM read data (asynchronous)

Behaviour:
- Slot phase register toggles every clock.
  - phase 0 = video access cycle.
  - phase 1 = shared access cycle (clear or CPU).
- All ram_* outputs are registered, loaded at the edge entering each access cycle, and held stable for the full cycle.
- ram_d is sampled at the edge ending the access cycle.
- Video slot (edge entering phase 0):
  - If vid_en=1: ram_a=vid_addr, ram_cs1_n=0, ram_w_n=1.
  - At the next edge: vid_data<=ram_d and vid_valid=1 for exactly that one following cycle.
  - If vid_en=0: ram_cs1_n=1, ram_w_n=1, ram_a holds its previous value.
  - The video slot is never given to another requester.
- Shared slot (edge entering phase 1), fixed priority:
  1. Clear: applies if clr_busy is set, or clr_start is sampled high at this edge. Action: ram_a=clear counter, ram_i=CLEAR_VALUE, ram_cs1_n=0, ram_w_n=0.
  2. CPU: applies if cpu_req=1 and clear is not active. Action: ram_a=cpu_addr, ram_cs1_n=0, ram_w_n=~cpu_we, ram_i=cpu_wdata.
  3. Otherwise the slot is idle: cs1_n=1, w_n=1.
- CPU completion:
  - At the edge ending the CPU access cycle: cpu_ack=1 for one cycle.
  - On a read, cpu_rdata<=ram_d; on a write, cpu_rdata holds its previous value.
  - CPU latency from grant edge to ack = 1 clock; worst-case wait for a slot = 2 clocks plus any clear time.
- CPU requester rule: drop cpu_req during the ack cycle. If cpu_req is still high at the next shared-slot edge, it is a new access.
- ram_w_n is high in every cycle except a granted write access cycle.
- Clear engine:
  - clr_start high at any edge while idle: clr_busy<=1, 8-bit counter<=0.
  - Each shared slot writes one address, then the counter increments.
  - After address 255 is written, at the edge ending that access: clr_busy<=0, clr_done=1 for one cycle, counter wraps to 0.
  - Total = 256 shared slots (512 clocks).
  - clr_start while busy is ignored; the clear does not restart.
  - CPU requests stall (no ack) for the whole clear, then are served in the first shared slot after clr_busy falls.
- Simultaneous events at a phase-1 edge: clr_start and cpu_req both high → clear wins and the CPU waits.
- Reset:
  - Output values: ram_a=0, ram_i=0, ram_cs1_n=1, ram_w_n=1, vid_data=0, vid_valid=0, cpu_ack=0, cpu_rdata=0, clr_busy=0, clr_done=0, counter=0.
  - phase resets to 1, so the first edge after reset is released enters phase 0.
  - Reset mid-clear aborts it: no clr_done, RAM left partially cleared.
  - Reset mid-CPU access drops the access with no ack.

Test Plan:
- Video read: preload RAM[0x5A]=4'hC; vid_en=1, vid_addr=0x5A sampled at a phase-0 edge → ram_a=0x5A, cs1_n=0 for one cycle; next cycle vid_valid=1, vid_data=4'hC, then vid_valid=0.
- CPU write then read: write 0x33←4'h7 → one cycle with ram_w_n=0 and cs1_n=0 in phase 1, cpu_ack pulse. Then read 0x33 → cpu_ack with cpu_rdata=4'h7. Video slots unaffected throughout.
- Concurrent traffic: vid_en held high with incrementing address, plus back-to-back CPU reads → video strobes every 2 clocks, a CPU ack every 4 clocks, and no video/CPU address is ever driven in the wrong phase.
- Clear with CLEAR_VALUE=4'h9:
  - clr_start pulse, then cpu_req raised 10 clocks later.
  - clr_busy stays high for 512 clocks, then clr_done pulses once.
  - All 256 locations read back 4'h9.
  - CPU ack arrives only after clr_busy falls.
  - A second clr_start mid-clear is ignored (done still at 512 clocks).
- Collision: clr_start and cpu_req high at the same phase-1 edge → the first shared write goes to address 0 with data CLEAR_VALUE, and there is no cpu_ack until the clear completes.
- Reset mid-clear at counter 0x80 → all outputs at reset values next cycle, no clr_done. Locations 0x00–0x7F are cleared and 0x80–0xFF keep their old data.
